// File: rtl/input_mems_pingpong.sv
// Double-buffered matrix input loader for the matrix-multiply datapath.
// Streams A (M x K) and B (K x N) over an AXI-Stream-style input into one of
// two load sets while the compute engine reads the other set. A load with
// new_A=0 streams only B and reuses the most recently loaded A bank.
module input_mems_pingpong #(
    parameter int unsigned INW  = 12,
    parameter int unsigned M    = 7,
    parameter int unsigned N    = 9,
    parameter int unsigned MAXK = 8,
    localparam int unsigned K_BITS      = $clog2(MAXK + 1),
    localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK),
    localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INW-1:0]                AXIS_TDATA,
    input  logic                          AXIS_TVALID,
    input  logic [K_BITS:0]               AXIS_TUSER,
    output logic                          AXIS_TREADY,
    output logic                          matrices_loaded,
    input  logic                          compute_finished,
    output logic [K_BITS-1:0]             K,
    input  logic [A_ADDR_BITS-1:0]        A_read_addr,
    output logic signed [INW-1:0]         A_data,
    input  logic [B_ADDR_BITS-1:0]        B_read_addr,
    output logic signed [INW-1:0]         B_data
);

    localparam int unsigned CNT_BITS =
        (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;

    state_t                        state, state_n;
    logic [1:0]                    full, full_n;
    logic [1:0][K_BITS-1:0]        k_q, k_n;
    logic [1:0]                    a_src, a_src_n;
    logic [1:0]                    a_valid, a_valid_n;
    logic                          latest_a, latest_a_n;
    logic                          a_tgt, a_tgt_n;
    logic                          wr_set, wr_set_n;
    logic                          rd_set, rd_set_n;
    logic [CNT_BITS-1:0]           cnt, cnt_n;
    logic [K_BITS-1:0]             cur_k, cur_k_n;
    logic                          tready_n, loaded_n;
    logic [K_BITS-1:0]             k_out_n;

    logic                          xfer, k_ok, user_new_a, tgt_idle;
    logic [K_BITS-1:0]             user_k;
    logic                          a_we, b_we, a_wbank;
    logic [A_ADDR_BITS-1:0]        a_waddr;
    logic [B_ADDR_BITS-1:0]        b_waddr;

    logic [INW-1:0] a_mem [2**(A_ADDR_BITS+1)];
    logic [INW-1:0] b_mem [2**(B_ADDR_BITS+1)];

    // State register for the load FSM, set bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            full            <= '0;
            k_q             <= '0;
            a_src           <= '0;
            a_valid         <= '0;
            latest_a        <= 1'b0;
            a_tgt           <= 1'b0;
            wr_set          <= 1'b0;
            rd_set          <= 1'b0;
            cnt             <= '0;
            cur_k           <= '0;
            AXIS_TREADY     <= 1'b0;
            matrices_loaded <= 1'b0;
            K               <= '0;
        end else begin
            state           <= state_n;
            full            <= full_n;
            k_q             <= k_n;
            a_src           <= a_src_n;
            a_valid         <= a_valid_n;
            latest_a        <= latest_a_n;
            a_tgt           <= a_tgt_n;
            wr_set          <= wr_set_n;
            rd_set          <= rd_set_n;
            cnt             <= cnt_n;
            cur_k           <= cur_k_n;
            AXIS_TREADY     <= tready_n;
            matrices_loaded <= loaded_n;
            K               <= k_out_n;
        end
    end

    // Next-state logic: loading, set completion, set release and write strobes.
    always_comb begin
        state_n    = state;
        full_n     = full;
        k_n        = k_q;
        a_src_n    = a_src;
        a_valid_n  = a_valid;
        latest_a_n = latest_a;
        a_tgt_n    = a_tgt;
        wr_set_n   = wr_set;
        rd_set_n   = rd_set;
        cnt_n      = cnt;
        cur_k_n    = cur_k;
        a_we       = 1'b0;
        b_we       = 1'b0;
        a_wbank    = a_tgt;
        a_waddr    = cnt[A_ADDR_BITS-1:0];
        b_waddr    = cnt[B_ADDR_BITS-1:0];

        xfer       = AXIS_TVALID && AXIS_TREADY;
        user_new_a = AXIS_TUSER[0];
        user_k     = AXIS_TUSER[K_BITS:1];
        k_ok       = (user_k != '0) && (user_k <= K_BITS'(MAXK));
        // Never overwrite the A bank a full (waiting or computing) set still uses.
        tgt_idle   = full[~wr_set] ? ~a_src[~wr_set] : ~latest_a;

        unique case (state)
            IDLE: begin
                if (xfer && k_ok) begin
                    cur_k_n = user_k;
                    cnt_n   = CNT_BITS'(1);
                    if (user_new_a) begin
                        a_we                = 1'b1;
                        a_wbank             = tgt_idle;
                        a_waddr             = '0;
                        a_tgt_n             = tgt_idle;
                        a_valid_n[tgt_idle] = 1'b0;
                        state_n             = LOAD_A;
                    end else begin
                        b_we    = 1'b1;
                        b_waddr = '0;
                        state_n = LOAD_B;
                    end
                end
            end
            LOAD_A: begin
                if (xfer) begin
                    a_we = 1'b1;
                    if (cnt == CNT_BITS'(M * cur_k - 1)) begin
                        a_valid_n[a_tgt] = 1'b1;
                        latest_a_n       = a_tgt;
                        cnt_n            = '0;
                        state_n          = LOAD_B;
                    end else begin
                        cnt_n = cnt + CNT_BITS'(1);
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    b_we = 1'b1;
                    if (cnt == CNT_BITS'(N * cur_k - 1)) begin
                        full_n[wr_set]  = 1'b1;
                        k_n[wr_set]     = cur_k;
                        a_src_n[wr_set] = latest_a;
                        wr_set_n        = ~wr_set;
                        cnt_n           = '0;
                        state_n         = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_BITS'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A completing beat always targets the set that is not being read.
        if (compute_finished && matrices_loaded) begin
            full_n[rd_set] = 1'b0;
            rd_set_n       = ~rd_set;
        end

        tready_n = (state_n != IDLE) || !full_n[wr_set_n];
        loaded_n = full_n[rd_set_n];
        k_out_n  = full_n[rd_set_n] ? k_n[rd_set_n] : K;
    end

    // Memory write ports; the bank select forms the address MSB.
    always_ff @(posedge clk) begin
        if (a_we) a_mem[{a_wbank, a_waddr}] <= AXIS_TDATA;
        if (b_we) b_mem[{wr_set, b_waddr}]  <= AXIS_TDATA;
    end

    // Registered read ports for the read set; A reads 0 if its bank holds no valid A.
    always_ff @(posedge clk) begin
        if (reset) begin
            A_data <= '0;
            B_data <= '0;
        end else begin
            A_data <= a_valid[a_src[rd_set]] ? a_mem[{a_src[rd_set], A_read_addr}] : '0;
            B_data <= b_mem[{rd_set, B_read_addr}];
        end
    end

endmodule

// File: tb/tb_input_mems_pingpong.sv
// Directed self-checking bench for input_mems_pingpong.
module tb_input_mems_pingpong;

    localparam int M = 7;
    localparam int N = 9;

    logic                clk = 1'b0;
    logic                reset;
    logic [11:0]         AXIS_TDATA;
    logic                AXIS_TVALID;
    logic [4:0]          AXIS_TUSER;
    logic                AXIS_TREADY;
    logic                matrices_loaded;
    logic                compute_finished;
    logic [3:0]          K;
    logic [5:0]          A_read_addr;
    logic signed [11:0]  A_data;
    logic [6:0]          B_read_addr;
    logic signed [11:0]  B_data;

    int tests = 0;
    int fails = 0;

    input_mems_pingpong dut (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TUSER(AXIS_TUSER),
        .AXIS_TREADY(AXIS_TREADY), .matrices_loaded(matrices_loaded),
        .compute_finished(compute_finished), .K(K),
        .A_read_addr(A_read_addr), .A_data(A_data),
        .B_read_addr(B_read_addr), .B_data(B_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int data, input logic [4:0] user);
        int waitc = 0;
        AXIS_TDATA  = 12'(data);
        AXIS_TUSER  = user;
        AXIS_TVALID = 1'b1;
        while (!AXIS_TREADY && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!AXIS_TREADY) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: tready=%0b required 1", AXIS_TREADY);
        end
        tick();
        AXIS_TVALID = 1'b0;
    endtask

    // Sends every beat of a load except the final B beat.
    task automatic load_body(input bit new_a, input int k, input int abase,
                             input int bbase, input bit gaps);
        logic [4:0] user;
        user = {4'(k), new_a};
        if (new_a) begin
            for (int i = 0; i < M * k; i++) begin
                if (gaps && $urandom_range(0, 1) == 1) tick();
                send_beat(abase + i, user);
            end
        end
        for (int i = 0; i < k * N - 1; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) tick();
            send_beat(bbase + i, user);
        end
    endtask

    task automatic pulse_finish();
        compute_finished = 1'b1;
        tick();
        compute_finished = 1'b0;
    endtask

    task automatic read_ab(input int aa, input int ba);
        A_read_addr = 6'(aa);
        B_read_addr = 7'(ba);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL rst_tready: got %0b, required 0", AXIS_TREADY); end
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL rst_loaded: got %0b, required 0", matrices_loaded); end
        tests++; if (K !== 4'd0) begin fails++; $display("FAIL rst_k: got %0d, required 0", K); end
        tests++; if (A_data !== 12'sd0) begin fails++; $display("FAIL rst_adata: got %0d, required 0", A_data); end
        tests++; if (B_data !== 12'sd0) begin fails++; $display("FAIL rst_bdata: got %0d, required 0", B_data); end
        reset = 1'b0;
        tick();
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL rst_release_tready: got %0b, required 1", AXIS_TREADY); end
    endtask

    task automatic test_basic();
        load_body(1'b1, 4, 1, 29, 1'b0);
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL basic_early_loaded: got %0b, required 0", matrices_loaded); end
        send_beat(64, 5'd9);
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL basic_loaded: got %0b, required 1", matrices_loaded); end
        tests++; if (K !== 4'd4) begin fails++; $display("FAIL basic_k: got %0d, required 4", K); end
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL basic_tready: got %0b, required 1", AXIS_TREADY); end
        read_ab(5, 0);
        tests++; if (A_data !== 12'(6)) begin fails++; $display("FAIL basic_a5: got %0d, required 6", A_data); end
        tests++; if (B_data !== 12'(29)) begin fails++; $display("FAIL basic_b0: got %0d, required 29", B_data); end
        read_ab(27, 35);
        tests++; if (A_data !== 12'(28)) begin fails++; $display("FAIL basic_a27: got %0d, required 28", A_data); end
        tests++; if (B_data !== 12'(64)) begin fails++; $display("FAIL basic_b35: got %0d, required 64", B_data); end
    endtask

    task automatic test_a_reuse();
        load_body(1'b0, 4, 0, 100, 1'b0);
        send_beat(135, 5'd8);
        tests++; if (AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL reuse_tready_full: got %0b, required 0", AXIS_TREADY); end
        pulse_finish();
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL reuse_loaded: got %0b, required 1", matrices_loaded); end
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL reuse_tready_freed: got %0b, required 1", AXIS_TREADY); end
        read_ab(5, 0);
        tests++; if (A_data !== 12'(6)) begin fails++; $display("FAIL reuse_a5: got %0d, required 6", A_data); end
        tests++; if (B_data !== 12'(100)) begin fails++; $display("FAIL reuse_b0: got %0d, required 100", B_data); end
        read_ab(0, 35);
        tests++; if (B_data !== 12'(135)) begin fails++; $display("FAIL reuse_b35: got %0d, required 135", B_data); end
        pulse_finish();
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL reuse_drained: got %0b, required 0", matrices_loaded); end
        tests++; if (K !== 4'd4) begin fails++; $display("FAIL reuse_k_hold: got %0d, required 4", K); end
    endtask

    task automatic test_ping_pong();
        load_body(1'b1, 4, 1, 29, 1'b0);
        send_beat(64, 5'd9);
        load_body(1'b1, 8, 300, 500, 1'b0);
        send_beat(571, 5'd17);
        tests++; if (AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL pp_tready_full: got %0b, required 0", AXIS_TREADY); end
        tests++; if (K !== 4'd4) begin fails++; $display("FAIL pp_k_set0: got %0d, required 4", K); end
        read_ab(5, 0);
        tests++; if (A_data !== 12'(6)) begin fails++; $display("FAIL pp_set0_a5: got %0d, required 6", A_data); end
        pulse_finish();
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL pp_loaded: got %0b, required 1", matrices_loaded); end
        tests++; if (K !== 4'd8) begin fails++; $display("FAIL pp_k_set1: got %0d, required 8", K); end
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL pp_tready_freed: got %0b, required 1", AXIS_TREADY); end
        read_ab(5, 0);
        tests++; if (A_data !== 12'(305)) begin fails++; $display("FAIL pp_set1_a5: got %0d, required 305", A_data); end
        tests++; if (B_data !== 12'(500)) begin fails++; $display("FAIL pp_set1_b0: got %0d, required 500", B_data); end
        read_ab(55, 71);
        tests++; if (A_data !== 12'(355)) begin fails++; $display("FAIL pp_set1_a55: got %0d, required 355", A_data); end
        tests++; if (B_data !== 12'(571)) begin fails++; $display("FAIL pp_set1_b71: got %0d, required 571", B_data); end
        pulse_finish();
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL pp_drained: got %0b, required 0", matrices_loaded); end
    endtask

    task automatic test_backpressure();
        load_body(1'b1, 3, 700, 800, 1'b1);
        tick();
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL bp_early_loaded: got %0b, required 0", matrices_loaded); end
        send_beat(826, 5'd7);
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL bp_loaded: got %0b, required 1", matrices_loaded); end
        tests++; if (K !== 4'd3) begin fails++; $display("FAIL bp_k: got %0d, required 3", K); end
        read_ab(0, 0);
        tests++; if (A_data !== 12'(700)) begin fails++; $display("FAIL bp_a0: got %0d, required 700", A_data); end
        tests++; if (B_data !== 12'(800)) begin fails++; $display("FAIL bp_b0: got %0d, required 800", B_data); end
        read_ab(20, 26);
        tests++; if (A_data !== 12'(720)) begin fails++; $display("FAIL bp_a20: got %0d, required 720", A_data); end
        tests++; if (B_data !== 12'(826)) begin fails++; $display("FAIL bp_b26: got %0d, required 826", B_data); end
        pulse_finish();
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 10; i++) send_beat(900 + i, 5'd9);
        reset = 1'b1;
        tick();
        tests++; if (AXIS_TREADY !== 1'b0) begin fails++; $display("FAIL mid_rst_tready: got %0b, required 0", AXIS_TREADY); end
        tests++; if (K !== 4'd0) begin fails++; $display("FAIL mid_rst_k: got %0d, required 0", K); end
        tests++; if (A_data !== 12'sd0) begin fails++; $display("FAIL mid_rst_adata: got %0d, required 0", A_data); end
        tests++; if (B_data !== 12'sd0) begin fails++; $display("FAIL mid_rst_bdata: got %0d, required 0", B_data); end
        tick();
        reset = 1'b0;
        tick();
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL mid_release_tready: got %0b, required 1", AXIS_TREADY); end
        load_body(1'b1, 4, 1, 29, 1'b0);
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL mid_early_loaded: got %0b, required 0", matrices_loaded); end
        send_beat(64, 5'd9);
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL mid_loaded: got %0b, required 1", matrices_loaded); end
        read_ab(0, 0);
        tests++; if (A_data !== 12'(1)) begin fails++; $display("FAIL mid_a0: got %0d, required 1", A_data); end
        tests++; if (B_data !== 12'(29)) begin fails++; $display("FAIL mid_b0: got %0d, required 29", B_data); end
        pulse_finish();
    endtask

    task automatic test_boundaries();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_beat(77, 5'd1);
        send_beat(78, 5'd19);
        tick();
        tests++; if (matrices_loaded !== 1'b0) begin fails++; $display("FAIL bnd_k0_loaded: got %0b, required 0", matrices_loaded); end
        tests++; if (AXIS_TREADY !== 1'b1) begin fails++; $display("FAIL bnd_k0_tready: got %0b, required 1", AXIS_TREADY); end
        load_body(1'b0, 2, 0, 40, 1'b0);
        send_beat(57, 5'd4);
        tests++; if (matrices_loaded !== 1'b1) begin fails++; $display("FAIL bnd_noa_loaded: got %0b, required 1", matrices_loaded); end
        tests++; if (K !== 4'd2) begin fails++; $display("FAIL bnd_noa_k: got %0d, required 2", K); end
        read_ab(0, 0);
        tests++; if (A_data !== 12'sd0) begin fails++; $display("FAIL bnd_noa_a0: got %0d, required 0", A_data); end
        tests++; if (B_data !== 12'(40)) begin fails++; $display("FAIL bnd_noa_b0: got %0d, required 40", B_data); end
        read_ab(13, 17);
        tests++; if (A_data !== 12'sd0) begin fails++; $display("FAIL bnd_noa_a13: got %0d, required 0", A_data); end
        tests++; if (B_data !== 12'(57)) begin fails++; $display("FAIL bnd_noa_b17: got %0d, required 57", B_data); end
    endtask

    initial begin
        reset            = 1'b1;
        AXIS_TDATA       = '0;
        AXIS_TVALID      = 1'b0;
        AXIS_TUSER       = '0;
        compute_finished = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;
        test_reset();
        test_basic();
        test_a_reuse();
        test_ping_pong();
        test_backpressure();
        test_reset_midload();
        test_boundaries();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
